// File: rtl/audio_sample_scheduler.sv
// Groups buffered stereo samples (up to 4 pairs) into HDMI audio sample packets and handshakes with the packet scheduler.
// Optional partial-packet wait limit: define AUDIO_SCHED_TIMEOUT_EN.
module audio_sample_scheduler #(
    parameter int FIFO_DEPTH      = 8,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk_pixel,
    input  logic                       reset_n,
    input  logic                       sample_valid,
    input  logic [AUDIO_BIT_WIDTH-1:0] sample_left,
    input  logic [AUDIO_BIT_WIDTH-1:0] sample_right,
    output logic                       packet_req,
    input  logic                       packet_grant,
    input  logic                       packet_done,
    output logic [7:0]                 frame_counter,
    output logic [3:0][1:0][23:0]      audio_sample_word,
    output logic [3:0]                 audio_sample_word_present,
    output logic                       overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int PAD = 24 - AUDIO_BIT_WIDTH;
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ASSEMBLE, REQUEST, SEND} state_t;

    state_t        state_r;
    logic [47:0]   fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic          assemble_done_s;
    logic [23:0]   left_word_s;
    logic [23:0]   right_word_s;
    logic [2:0]    slot_count_s;
    logic [8:0]    fc_sum_s;
    logic [7:0]    fc_next_s;
`ifdef AUDIO_SCHED_TIMEOUT_EN
    logic [15:0]   wait_cnt_r;
`endif

    function automatic logic [2:0] popcount4(input logic [3:0] mask);
        popcount4 = {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};
    endfunction

    // FIFO status, pop decision and frame counter advance (modulo 192, done in 9 bits)
    always_comb begin
        fifo_full_s  = (count_r == CNT_FULL);
        fifo_empty_s = (count_r == {CW{1'b0}});
        push_s       = sample_valid & ~fifo_full_s;
        left_word_s  = 24'(sample_left) << PAD;
        right_word_s = 24'(sample_right) << PAD;
        slot_count_s = popcount4(audio_sample_word_present);
        if ((state_r == ASSEMBLE) && (slot_count_s != 3'd4) && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
`ifdef AUDIO_SCHED_TIMEOUT_EN
        assemble_done_s = (slot_count_s == 3'd4) ||
                          (fifo_empty_s && (slot_count_s != 3'd0) &&
                           (wait_cnt_r == 16'(TIMEOUT_CYCLES - 1)));
`else
        assemble_done_s = (slot_count_s == 3'd4) || (fifo_empty_s && (slot_count_s != 3'd0));
`endif
        fc_sum_s = {1'b0, frame_counter} + {6'd0, slot_count_s};
        if (fc_sum_s >= 9'd192) begin
            fc_next_s = 8'(fc_sum_s - 9'd192);
        end else begin
            fc_next_s = fc_sum_s[7:0];
        end
    end

    // Sample storage; left in the low half, right in the high half to match the slot layout
    always_ff @(posedge clk_pixel) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {right_word_s, left_word_s};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            overflow <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (sample_valid && fifo_full_s) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef AUDIO_SCHED_TIMEOUT_EN
    // Partial-packet wait counter: runs only while starved with 1..3 slots filled
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 16'd0;
        end else if ((state_r != ASSEMBLE) || pop_s || assemble_done_s) begin
            wait_cnt_r <= 16'd0;
        end else if (fifo_empty_s && (slot_count_s != 3'd0)) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end
    end
`endif

    // Packet FSM with registered request and staged slot outputs
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_r                   <= IDLE;
            packet_req                <= 1'b0;
            frame_counter             <= 8'd0;
            audio_sample_word         <= 192'd0;
            audio_sample_word_present <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r <= ASSEMBLE;
                    end
                end
                ASSEMBLE: begin
                    if (pop_s) begin
                        audio_sample_word[slot_count_s[1:0]]         <= fifo_mem_r[rd_ptr_r];
                        audio_sample_word_present[slot_count_s[1:0]] <= 1'b1;
                    end
                    if (assemble_done_s) begin
                        state_r    <= REQUEST;
                        packet_req <= 1'b1;
                    end
                end
                REQUEST: begin
                    // a done strobe coincident with the grant belongs to no packet yet
                    if (packet_grant) begin
                        state_r    <= SEND;
                        packet_req <= 1'b0;
                    end
                end
                SEND: begin
                    if (packet_done) begin
                        frame_counter             <= fc_next_s;
                        audio_sample_word_present <= 4'b0000;
                        state_r                   <= IDLE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    packet_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed self-checking bench for audio_sample_scheduler (default parameters).
module tb_audio_sample_scheduler;

    logic                   clk_pixel = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   sample_valid = 1'b0;
    logic [15:0]            sample_left = 16'h0000;
    logic [15:0]            sample_right = 16'h0000;
    logic                   packet_req;
    logic                   packet_grant = 1'b0;
    logic                   packet_done = 1'b0;
    logic [7:0]             frame_counter;
    logic [3:0][1:0][23:0]  audio_sample_word;
    logic [3:0]             audio_sample_word_present;
    logic                   overflow;

    int vec_cnt = 0;
    int err_cnt = 0;

    audio_sample_scheduler #(.FIFO_DEPTH(8), .AUDIO_BIT_WIDTH(16), .TIMEOUT_CYCLES(64)) dut (
        .clk_pixel(clk_pixel),
        .reset_n(reset_n),
        .sample_valid(sample_valid),
        .sample_left(sample_left),
        .sample_right(sample_right),
        .packet_req(packet_req),
        .packet_grant(packet_grant),
        .packet_done(packet_done),
        .frame_counter(frame_counter),
        .audio_sample_word(audio_sample_word),
        .audio_sample_word_present(audio_sample_word_present),
        .overflow(overflow)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        sample_valid = 1'b1;
        sample_left  = l;
        sample_right = r;
        @(negedge clk_pixel);
        sample_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_pixel);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (packet_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_pixel);
        end
    endtask

    task automatic pulse_grant();
        packet_grant = 1'b1;
        @(negedge clk_pixel);
        packet_grant = 1'b0;
    endtask

    task automatic pulse_done();
        packet_done = 1'b1;
        @(negedge clk_pixel);
        packet_done = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) strobe(16'h5555, 16'hAAAA);
        idle_cycles(2);
        vec_cnt++; if (packet_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req: got %0b want 0", packet_req); end
        vec_cnt++; if (frame_counter !== 8'd0) begin err_cnt++; $display("FAIL reset_fc: got %0d want 0", frame_counter); end
        vec_cnt++; if (audio_sample_word !== 192'd0) begin err_cnt++; $display("FAIL reset_word: got %h want 0", audio_sample_word); end
        vec_cnt++; if (audio_sample_word_present !== 4'b0000) begin err_cnt++; $display("FAIL reset_present: got %b want 0000", audio_sample_word_present); end
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
        reset_n = 1'b1;
        idle_cycles(6);
        vec_cnt++; if (packet_req !== 1'b0) begin err_cnt++; $display("FAIL post_reset_req: got %0b want 0", packet_req); end
        vec_cnt++; if (audio_sample_word_present !== 4'b0000) begin err_cnt++; $display("FAIL post_reset_present: got %b want 0000", audio_sample_word_present); end
    endtask

    task automatic test_full_packet();
        bit ok;
        for (int i = 0; i < 4; i++) strobe(16'h1234, 16'hABCD);
        wait_req(ok);
        vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL full_req: got %0b want 1", ok); end
        vec_cnt++; if (audio_sample_word_present !== 4'b1111) begin err_cnt++; $display("FAIL full_present: got %b want 1111", audio_sample_word_present); end
        vec_cnt++; if (audio_sample_word[0][0] !== 24'h123400) begin err_cnt++; $display("FAIL full_w0L: got %h want 123400", audio_sample_word[0][0]); end
        vec_cnt++; if (audio_sample_word[3][1] !== 24'hABCD00) begin err_cnt++; $display("FAIL full_w3R: got %h want abcd00", audio_sample_word[3][1]); end
        vec_cnt++; if (frame_counter !== 8'd0) begin err_cnt++; $display("FAIL full_fc_before: got %0d want 0", frame_counter); end
        pulse_grant();
        vec_cnt++; if (packet_req !== 1'b0) begin err_cnt++; $display("FAIL full_req_drop: got %0b want 0", packet_req); end
        pulse_done();
        vec_cnt++; if (frame_counter !== 8'd4) begin err_cnt++; $display("FAIL full_fc_after: got %0d want 4", frame_counter); end
        vec_cnt++; if (audio_sample_word_present !== 4'b0000) begin err_cnt++; $display("FAIL full_present_clr: got %b want 0000", audio_sample_word_present); end
    endtask

    task automatic test_latency();
        bit ok;
        strobe(16'h0F0F, 16'hF0F0);
`ifndef AUDIO_SCHED_TIMEOUT_EN
        idle_cycles(2);
        vec_cnt++; if (packet_req !== 1'b0) begin err_cnt++; $display("FAIL lat_early: got %0b want 0", packet_req); end
        idle_cycles(1);
        vec_cnt++; if (packet_req !== 1'b1) begin err_cnt++; $display("FAIL lat_4cyc: got %0b want 1", packet_req); end
`endif
        wait_req(ok);
        vec_cnt++; if (audio_sample_word_present !== 4'b0001) begin err_cnt++; $display("FAIL lat_present: got %b want 0001", audio_sample_word_present); end
        pulse_grant();
        pulse_done();
        vec_cnt++; if (frame_counter !== 8'd5) begin err_cnt++; $display("FAIL lat_fc: got %0d want 5", frame_counter); end
    endtask

    task automatic test_wrap();
        bit ok;
        bit all_ok = 1'b1;
        for (int p = 0; p < 46; p++) begin
            for (int i = 0; i < 4; i++) strobe(16'(p * 4 + i), 16'hC000);
            wait_req(ok);
            all_ok &= ok;
            pulse_grant();
            pulse_done();
        end
        strobe(16'h7777, 16'h8888);
        wait_req(ok);
        all_ok &= ok;
        pulse_grant();
        pulse_done();
        vec_cnt++; if (all_ok !== 1'b1) begin err_cnt++; $display("FAIL wrap_fill_reqs: got %0b want 1", all_ok); end
        vec_cnt++; if (frame_counter !== 8'd190) begin err_cnt++; $display("FAIL wrap_fc_190: got %0d want 190", frame_counter); end
        for (int i = 0; i < 3; i++) strobe(16'h2000 + 16'(i), 16'h3000);
        wait_req(ok);
        vec_cnt++; if (audio_sample_word_present !== 4'b0111) begin err_cnt++; $display("FAIL wrap_present: got %b want 0111", audio_sample_word_present); end
        vec_cnt++; if (audio_sample_word[2][0] !== 24'h200200) begin err_cnt++; $display("FAIL wrap_w2L: got %h want 200200", audio_sample_word[2][0]); end
        pulse_grant();
        pulse_done();
        vec_cnt++; if (frame_counter !== 8'd1) begin err_cnt++; $display("FAIL wrap_fc: got %0d want 1", frame_counter); end
    endtask

    task automatic test_overflow();
        bit ok;
        strobe(16'h4444, 16'h5555);
        wait_req(ok);
        pulse_grant();
        for (int i = 1; i <= 9; i++) strobe(16'(i), 16'h0100 + 16'(i));
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        pulse_done();
        vec_cnt++; if (frame_counter !== 8'd2) begin err_cnt++; $display("FAIL ovf_fc: got %0d want 2", frame_counter); end
        for (int pk = 0; pk < 2; pk++) begin
            wait_req(ok);
            vec_cnt++; if (audio_sample_word_present !== 4'b1111) begin err_cnt++; $display("FAIL ovf_present%0d: got %b want 1111", pk, audio_sample_word_present); end
            for (int s = 0; s < 4; s++) begin
                vec_cnt++;
                if (audio_sample_word[s][0] !== {16'(pk * 4 + s + 1), 8'h00} ||
                    audio_sample_word[s][1] !== {16'h0100 + 16'(pk * 4 + s + 1), 8'h00}) begin
                    err_cnt++;
                    $display("FAIL ovf_slot%0d_%0d: got %h/%h want sample %0d", pk, s,
                             audio_sample_word[s][0], audio_sample_word[s][1], pk * 4 + s + 1);
                end
            end
            pulse_grant();
            pulse_done();
        end
        idle_cycles(10);
        vec_cnt++; if (packet_req !== 1'b0) begin err_cnt++; $display("FAIL ovf_no_9th: got req %0b want 0", packet_req); end
        vec_cnt++; if (frame_counter !== 8'd10) begin err_cnt++; $display("FAIL ovf_fc_end: got %0d want 10", frame_counter); end
    endtask

    task automatic test_handshake();
        bit ok;
        pulse_grant();
        pulse_done();
        idle_cycles(3);
        vec_cnt++; if (packet_req !== 1'b0 || audio_sample_word_present !== 4'b0000 || frame_counter !== 8'd10) begin
            err_cnt++; $display("FAIL hs_idle_strobes: got req %0b pres %b fc %0d want 0 0000 10", packet_req, audio_sample_word_present, frame_counter);
        end
        strobe(16'h9999, 16'h6666);
        wait_req(ok);
        pulse_done();
        vec_cnt++; if (packet_req !== 1'b1) begin err_cnt++; $display("FAIL hs_done_in_req: got %0b want 1", packet_req); end
        packet_grant = 1'b1;
        packet_done  = 1'b1;
        @(negedge clk_pixel);
        packet_grant = 1'b0;
        packet_done  = 1'b0;
        vec_cnt++; if (packet_req !== 1'b0 || audio_sample_word_present !== 4'b0001 || frame_counter !== 8'd10) begin
            err_cnt++; $display("FAIL hs_grant_done: got req %0b pres %b fc %0d want 0 0001 10", packet_req, audio_sample_word_present, frame_counter);
        end
        idle_cycles(2);
        pulse_done();
        vec_cnt++; if (frame_counter !== 8'd11 || audio_sample_word_present !== 4'b0000) begin
            err_cnt++; $display("FAIL hs_send_done: got fc %0d pres %b want 11 0000", frame_counter, audio_sample_word_present);
        end
    endtask

`ifdef AUDIO_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        strobe(16'h1111, 16'h2222);
        idle_cycles(2);
        idle_cycles(63);
        vec_cnt++; if (packet_req !== 1'b0) begin err_cnt++; $display("FAIL to_early: got %0b want 0", packet_req); end
        idle_cycles(1);
        vec_cnt++; if (packet_req !== 1'b1) begin err_cnt++; $display("FAIL to_64: got %0b want 1", packet_req); end
        pulse_grant();
        pulse_done();
        strobe(16'h1111, 16'h2222);
        idle_cycles(32);
        strobe(16'h3333, 16'h4444);
        wait_req(ok);
        vec_cnt++; if (audio_sample_word_present !== 4'b0011) begin err_cnt++; $display("FAIL to_restart: got %b want 0011", audio_sample_word_present); end
        pulse_grant();
        pulse_done();
    endtask
`endif

    initial begin
        test_reset();
        test_full_packet();
        test_latency();
        test_wrap();
        test_overflow();
        test_handshake();
`ifdef AUDIO_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
